// File: rtl/dmem_access_ctrl.sv
// Round-robin two-port data-memory access controller with read-modify-write for sub-word stores.
// States: IDLE grant a port | ACCESS read/write/check | MERGE_WR write merged word | RESP hold response.
module dmem_access_ctrl #(
  parameter int DEPTH_WORDS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  input  logic [3:0]  p0_req_be,
  output logic        p0_rsp_valid,
  input  logic        p0_rsp_ready,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  input  logic [3:0]  p1_req_be,
  output logic        p1_rsp_valid,
  input  logic        p1_rsp_ready,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_e;

  state_e      state_q, state_d;
  logic        port_q, port_d, rr_last_q, rr_last_d, we_q, we_d, err_q, err_d;
  logic [29:0] widx_q, widx_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, merge_q, merge_d, merge_w;
  logic [3:0]  be_q, be_d;
  logic        gnt0, gnt1, rsp_hs;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{p0_req_addr[1:0], p1_req_addr[1:0]};

  // rr_last holds the last granted port; a tie goes to the other one.
  assign gnt0 = (state_q == IDLE) && !reset && p0_req_valid && (!p1_req_valid || rr_last_q);
  assign gnt1 = (state_q == IDLE) && !reset && p1_req_valid && !gnt0;
  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;

  assign p0_rsp_valid = !reset && (state_q == RESP) && !port_q;
  assign p1_rsp_valid = !reset && (state_q == RESP) && port_q;
  assign p0_rsp_rdata = p0_rsp_valid ? rdata_q : 32'h0;
  assign p1_rsp_rdata = p1_rsp_valid ? rdata_q : 32'h0;
  assign p0_rsp_err   = p0_rsp_valid & err_q;
  assign p1_rsp_err   = p1_rsp_valid & err_q;
  assign rsp_hs       = (state_q == RESP) && (port_q ? p1_rsp_ready : p0_rsp_ready);

  always_comb begin
    merge_w = mem_read_data;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merge_w[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      port_q    <= 1'b0;
      rr_last_q <= 1'b1;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      widx_q    <= 30'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      merge_q   <= 32'h0;
      be_q      <= 4'h0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      rr_last_q <= rr_last_d;
      we_q      <= we_d;
      err_q     <= err_d;
      widx_q    <= widx_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      merge_q   <= merge_d;
      be_q      <= be_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    port_d         = port_q;
    rr_last_d      = rr_last_q;
    we_d           = we_q;
    err_d          = err_q;
    widx_d         = widx_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    merge_d        = merge_q;
    be_d           = be_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 32'h0;
    mem_write_data = 32'h0;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          port_d    = gnt1;
          rr_last_d = gnt1;
          we_d      = gnt1 ? p1_req_we : p0_req_we;
          widx_d    = gnt1 ? p1_req_addr[31:2] : p0_req_addr[31:2];
          wdata_d   = gnt1 ? p1_req_wdata : p0_req_wdata;
          be_d      = gnt1 ? p1_req_be : p0_req_be;
          rdata_d   = 32'h0;
          err_d     = 1'b0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        mem_address = {widx_q, 2'b00};
        state_d     = RESP;
        if (widx_q >= DEPTH_W) begin
          err_d = 1'b1;
        end else if (!we_q) begin
          mem_read = 1'b1;
          rdata_d  = mem_read_data;
        end else if (be_q == 4'b1111) begin
          mem_write      = 1'b1;
          mem_write_data = wdata_q;
        end else if (be_q != 4'b0000) begin
          mem_read = 1'b1;
          merge_d  = merge_w;
          state_d  = MERGE_WR;
        end
      end
      MERGE_WR: begin
        mem_address    = {widx_q, 2'b00};
        mem_write      = 1'b1;
        mem_write_data = merge_q;
        state_d        = RESP;
      end
      RESP: begin
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Keep memory quiet while reset is held so an interrupted RMW never lands.
    if (reset) begin
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = 32'h0;
      mem_write_data = 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: combinational memory, transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_dmem_access_ctrl;

  localparam int DEPTH = 1000;

  logic        clk, reset;
  logic        p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
  logic [3:0]  p0_req_be;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
  logic [3:0]  p1_req_be;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        load_mem;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_access_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_be(p0_req_be),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
    .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_be(p1_req_be),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
    .p1_rsp_err(p1_rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    case (i)
      5:       return 32'hCAFE_F00D;
      8:       return 32'h1122_3344;
      9:       return 32'h5566_7788;
      default: return 32'hA500_0000 ^ 32'(i);
    endcase
  endfunction

  logic [31:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (mem_write && mem_address[31:2] < 30'd1000) begin
      mem[mem_address[31:2]] <= mem_write_data;
    end
  end
  assign mem_read_data = (mem_address[31:2] < 30'd1000) ? mem[mem_address[31:2]] : 32'h0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted request becomes a per-cycle strobe schedule
  // plus one response that appears a fixed number of cycles later.
  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          widx;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  bit          m_idle = 1'b1, m_rr_last = 1'b1, rsp_pend = 1'b0, rsp_port = 1'b0, rsp_err = 1'b0;
  logic [31:0] rsp_rdata = 32'h0;
  int          rsp_wait = 0;

  always @(negedge clk) begin
    bit          e_rd, e_wr, e_g0, e_g1, e_v0, e_v1, g_we;
    logic [31:0] e_addr, e_wd, g_addr, g_wd, merged;
    logic [3:0]  g_be;
    int          w;
    ent_t        ne;
    if (load_mem) for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    e_rd = 0; e_wr = 0; e_addr = 32'h0; e_wd = 32'h0;
    e_g0 = 0; e_g1 = 0; e_v0 = 0; e_v1 = 0;
    if (!reset) begin
      if (exp_q.size() > 0) begin
        e_rd = exp_q[0].rd; e_wr = exp_q[0].wr; e_addr = exp_q[0].addr; e_wd = exp_q[0].wdata;
      end
      if (m_idle) begin
        if (p0_req_valid && (!p1_req_valid || m_rr_last)) e_g0 = 1;
        else if (p1_req_valid) e_g1 = 1;
      end
      if (rsp_pend && rsp_wait == 0) begin
        e_v0 = !rsp_port; e_v1 = rsp_port;
      end
    end
    chk1("m_p0_req_ready", p0_req_ready, e_g0);
    chk1("m_p1_req_ready", p1_req_ready, e_g1);
    chk1("m_mem_read", mem_read, e_rd);
    chk1("m_mem_write", mem_write, e_wr);
    chk32("m_mem_address", mem_address, e_addr);
    if (e_wr) chk32("m_mem_write_data", mem_write_data, e_wd);
    chk1("m_p0_rsp_valid", p0_rsp_valid, e_v0);
    chk1("m_p1_rsp_valid", p1_rsp_valid, e_v1);
    if (e_v0) begin
      chk32("m_p0_rsp_rdata", p0_rsp_rdata, rsp_rdata);
      chk1("m_p0_rsp_err", p0_rsp_err, rsp_err);
    end
    if (e_v1) begin
      chk32("m_p1_rsp_rdata", p1_rsp_rdata, rsp_rdata);
      chk1("m_p1_rsp_err", p1_rsp_err, rsp_err);
    end
    if (reset) begin
      exp_q.delete();
      m_idle = 1; m_rr_last = 1; rsp_pend = 0; rsp_wait = 0;
    end else begin
      if (exp_q.size() > 0) begin
        if (exp_q[0].wr) ref_mem[exp_q[0].widx] = exp_q[0].wdata;
        void'(exp_q.pop_front());
      end
      if (rsp_pend) begin
        if (rsp_wait > 0) rsp_wait--;
        else if ((e_v0 && p0_rsp_ready) || (e_v1 && p1_rsp_ready)) begin
          rsp_pend = 0; m_idle = 1;
        end
      end
      if (e_g0 || e_g1) begin
        g_we   = e_g1 ? p1_req_we : p0_req_we;
        g_addr = e_g1 ? p1_req_addr : p0_req_addr;
        g_wd   = e_g1 ? p1_req_wdata : p0_req_wdata;
        g_be   = e_g1 ? p1_req_be : p0_req_be;
        w = int'(g_addr[31:2]);
        m_idle = 0; m_rr_last = e_g1;
        rsp_pend = 1; rsp_port = e_g1; rsp_rdata = 32'h0; rsp_err = 0; rsp_wait = 1;
        ne.rd = 0; ne.wr = 0; ne.addr = {g_addr[31:2], 2'b00}; ne.wdata = 32'h0; ne.widx = w;
        if (w >= DEPTH) begin
          rsp_err = 1;
          exp_q.push_back(ne);
        end else if (!g_we) begin
          rsp_rdata = ref_mem[w];
          ne.rd = 1;
          exp_q.push_back(ne);
        end else if (g_be == 4'hF) begin
          ne.wr = 1; ne.wdata = g_wd;
          exp_q.push_back(ne);
        end else if (g_be == 4'h0) begin
          exp_q.push_back(ne);
        end else begin
          merged = ref_mem[w];
          for (int b = 0; b < 4; b++) if (g_be[b]) merged[8*b +: 8] = g_wd[8*b +: 8];
          ne.rd = 1;
          exp_q.push_back(ne);
          ne.rd = 0; ne.wr = 1; ne.wdata = merged;
          exp_q.push_back(ne);
          rsp_wait = 2;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit v, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (port) begin
      p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = wd; p1_req_be = be;
    end else begin
      p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = wd; p0_req_be = be;
    end
  endtask

  task automatic xact(input bit port, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rdata, output logic err);
    bit got;
    got = 0; rdata = 32'hx; err = 1'bx;
    step;
    drive(port, 1, we, a, wd, be);
    for (int k = 0; k < 20; k++) begin
      #1;
      if (port ? p1_req_ready : p0_req_ready) begin got = 1; break; end
      step;
    end
    chk1("xact_grant_seen", got, 1'b1);
    step;
    drive(port, 0, 0, 32'h0, 32'h0, 4'h0);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (port ? p1_rsp_valid : p0_rsp_valid) begin
        rdata = port ? p1_rsp_rdata : p0_rsp_rdata;
        err   = port ? p1_rsp_err : p0_rsp_err;
        got   = 1;
        break;
      end
      step;
    end
    chk1("xact_rsp_seen", got, 1'b1);
    step;
  endtask

  task automatic chk_quiet(input string nm);
    chk1({nm, "_p0_req_ready"}, p0_req_ready, 1'b0);
    chk1({nm, "_p1_req_ready"}, p1_req_ready, 1'b0);
    chk1({nm, "_p0_rsp_valid"}, p0_rsp_valid, 1'b0);
    chk1({nm, "_p1_rsp_valid"}, p1_rsp_valid, 1'b0);
    chk32({nm, "_p0_rsp_rdata"}, p0_rsp_rdata, 32'h0);
    chk1({nm, "_p0_rsp_err"}, p0_rsp_err, 1'b0);
    chk1({nm, "_mem_read"}, mem_read, 1'b0);
    chk1({nm, "_mem_write"}, mem_write, 1'b0);
    chk32({nm, "_mem_address"}, mem_address, 32'h0);
    chk32({nm, "_mem_write_data"}, mem_write_data, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          gq[$];
    reset = 1; load_mem = 1;
    p0_rsp_ready = 1; p1_rsp_ready = 1;
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    step; step;
    load_mem = 0;
    step;
    reset = 0;
    #1;
    chk_quiet("rst");

    // Load port 0, word 5
    step; drive(0, 1, 0, 32'h14, 32'h0, 4'h0); #1;
    chk1("ld_ready", p0_req_ready, 1'b1);
    step; drive(0, 0, 0, 32'h0, 32'h0, 4'h0); #1;
    chk1("ld_mem_read", mem_read, 1'b1);
    chk32("ld_mem_address", mem_address, 32'h14);
    step; #1;
    chk1("ld_rsp_valid", p0_rsp_valid, 1'b1);
    chk32("ld_rsp_rdata", p0_rsp_rdata, 32'hCAFE_F00D);
    chk1("ld_rsp_err", p0_rsp_err, 1'b0);
    step; #1;
    chk1("ld_idle_again", p0_rsp_valid, 1'b0);

    // Partial store port 1, word 8
    step; drive(1, 1, 1, 32'h20, 32'hAABB_CCDD, 4'b0101); #1;
    chk1("ps_ready", p1_req_ready, 1'b1);
    step; drive(1, 0, 0, 32'h0, 32'h0, 4'h0); #1;
    chk1("ps_mem_read", mem_read, 1'b1);
    step; #1;
    chk1("ps_mem_write", mem_write, 1'b1);
    chk32("ps_mem_write_data", mem_write_data, 32'h11BB_33DD);
    step; #1;
    chk1("ps_rsp_valid", p1_rsp_valid, 1'b1);
    chk32("ps_rsp_rdata", p1_rsp_rdata, 32'h0);
    xact(1, 0, 32'h20, 32'h0, 4'h0, rd, er);
    chk32("ps_readback", rd, 32'h11BB_33DD);

    // Out-of-range load at word 1000, and last valid word 999
    step; drive(0, 1, 0, 32'h0000_0FA0, 32'h0, 4'h0); #1;
    chk1("oor_ready", p0_req_ready, 1'b1);
    step; drive(0, 0, 0, 32'h0, 32'h0, 4'h0); #1;
    chk1("oor_no_read", mem_read, 1'b0);
    chk1("oor_no_write", mem_write, 1'b0);
    step; #1;
    chk1("oor_rsp_valid", p0_rsp_valid, 1'b1);
    chk1("oor_rsp_err", p0_rsp_err, 1'b1);
    chk32("oor_rsp_rdata", p0_rsp_rdata, 32'h0);
    step;
    xact(0, 0, 32'h0000_0F9C, 32'h0, 4'h0, rd, er);
    chk1("w999_err", er, 1'b0);
    chk32("w999_rdata", rd, 32'hA500_03E7);

    // Full store, empty-byte-enable store, readback on port 1
    xact(0, 1, 32'h30, 32'h0BAD_BEEF, 4'hF, rd, er);
    chk1("fs_err", er, 1'b0);
    xact(0, 1, 32'h30, 32'hFFFF_FFFF, 4'h0, rd, er);
    chk1("be0_err", er, 1'b0);
    xact(1, 0, 32'h30, 32'h0, 4'h0, rd, er);
    chk32("be0_readback", rd, 32'h0BAD_BEEF);

    // Both ports requesting continuously
    step;
    drive(0, 1, 0, 32'h4, 32'h0, 4'h0);
    drive(1, 1, 0, 32'h8, 32'h0, 4'h0);
    for (int c = 0; c < 12; c++) begin
      #1;
      if (p0_req_ready) gq.push_back(0);
      if (p1_req_ready) gq.push_back(1);
      step;
    end
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    chk32("rr_grant_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < gq.size(); i++) chk32("rr_grant_port", 32'(gq[i]), 32'(i % 2));
    step;

    // Response backpressure on port 0 while port 1 waits
    step; drive(0, 1, 0, 32'h14, 32'h0, 4'h0); #1;
    chk1("bp_ready", p0_req_ready, 1'b1);
    step;
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(1, 1, 0, 32'h20, 32'h0, 4'h0);
    p0_rsp_ready = 0;
    #1;
    chk1("bp_p1_blocked_t1", p1_req_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step; #1;
      chk1("bp_rsp_valid", p0_rsp_valid, 1'b1);
      chk32("bp_rsp_rdata", p0_rsp_rdata, 32'hCAFE_F00D);
      chk1("bp_p1_blocked", p1_req_ready, 1'b0);
    end
    step; p0_rsp_ready = 1; #1;
    chk1("bp_hs_valid", p0_rsp_valid, 1'b1);
    chk1("bp_hs_p1_blocked", p1_req_ready, 1'b0);
    step; #1;
    chk1("bp_p1_granted", p1_req_ready, 1'b1);
    chk1("bp_p0_done", p0_rsp_valid, 1'b0);
    step; drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    step; step; step;

    // Reset while the merged word is being written
    step; drive(0, 1, 1, 32'h24, 32'hFFFF_FFFF, 4'b0011); #1;
    chk1("rm_ready", p0_req_ready, 1'b1);
    step; drive(0, 0, 0, 32'h0, 32'h0, 4'h0); #1;
    chk1("rm_mem_read", mem_read, 1'b1);
    step; reset = 1; #1;
    chk1("rm_no_write", mem_write, 1'b0);
    step; reset = 0; #1;
    chk_quiet("rm_after");
    chk32("rm_mem_unchanged", mem[9], 32'h5566_7788);
    xact(0, 0, 32'h24, 32'h0, 4'h0, rd, er);
    chk32("rm_readback", rd, 32'h5566_7788);

    step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
